// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: initial hash value, FSM encoding and the
// bitwise round/schedule functions used by the round core and schedule window.
package sha256_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ROUNDS = 2'd1;
    localparam logic [1:0] ST_FINAL  = 2'd2;

    // H0 occupies the top word, H7 the bottom word.
    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_w_mem.sv
// 16-word sliding message-schedule window; supplies W_t for round t and
// expands the schedule in place once the raw block words are used up.
module sha256_w_mem
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [511:0] block,
    input  logic         advance,
    input  logic [5:0]   t,
    output logic [31:0]  w
);

    // From t=16 on, win_r[0..15] holds W[t-16..t-1].
    logic [31:0] win_r [16];
    logic [31:0] new_w_s;

    // Next schedule word from the current window.
    always_comb begin
        new_w_s = small_s1(win_r[14]) + win_r[9] + small_s0(win_r[1]) + win_r[0];
    end

    // Raw block word for the first 16 rounds, expanded word afterwards.
    always_comb begin
        if (t < 6'd16) begin
            w = win_r[t[3:0]];
        end else begin
            w = new_w_s;
        end
    end

    // Window load on start, shift-in of each expanded word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= 32'd0;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= block[511 - 32*i -: 32];
            end
        end else if (advance && (t >= 6'd16)) begin
            for (int i = 0; i < 15; i++) begin
                win_r[i] <= win_r[i + 1];
            end
            win_r[15] <= new_w_s;
        end
    end

endmodule

// File: rtl/sha256_round_core.sv
// SHA-256 compression core: one round per cycle over a 512-bit block, chaining
// value kept across blocks, K constants fetched from an external ROM via w_ctr.
module sha256_round_core
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic [511:0] block,
    output logic [5:0]   w_ctr,
    input  logic [31:0]  K,
    output logic         ready,
    output logic [255:0] digest,
    output logic         digest_valid
);

    logic [1:0]  state_r;
    logic [5:0]  round_r;
    logic [31:0] wv_r [8];   // working variables a..h
    logic [31:0] hv_r [8];   // chaining value H0..H7
    logic        ready_r;
    logic        digest_valid_r;

    logic        start_s;
    logic        advance_s;
    logic [31:0] w_s;
    logic [31:0] t1_s;
    logic [31:0] t2_s;

    assign start_s   = (init | next) & ready_r & (state_r == ST_IDLE);
    assign advance_s = (state_r == ST_ROUNDS);

    sha256_w_mem u_w_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start_s),
        .block   (block),
        .advance (advance_s),
        .t       (round_r),
        .w       (w_s)
    );

    // Round temporaries.
    always_comb begin
        t1_s = wv_r[7] + big_s1(wv_r[4]) + ch(wv_r[4], wv_r[5], wv_r[6]) + K + w_s;
        t2_s = big_s0(wv_r[0]) + maj(wv_r[0], wv_r[1], wv_r[2]);
    end

    // Control FSM together with the working and chaining registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            round_r        <= 6'd0;
            ready_r        <= 1'b1;
            digest_valid_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                wv_r[i] <= 32'd0;
                hv_r[i] <= 32'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        for (int i = 0; i < 8; i++) begin
                            if (init) begin
                                hv_r[i] <= SHA256_IV[255 - 32*i -: 32];
                                wv_r[i] <= SHA256_IV[255 - 32*i -: 32];
                            end else begin
                                wv_r[i] <= hv_r[i];
                            end
                        end
                        round_r        <= 6'd0;
                        digest_valid_r <= 1'b0;
                        ready_r        <= 1'b0;
                        state_r        <= ST_ROUNDS;
                    end
                end
                ST_ROUNDS: begin
                    wv_r[7] <= wv_r[6];
                    wv_r[6] <= wv_r[5];
                    wv_r[5] <= wv_r[4];
                    wv_r[4] <= wv_r[3] + t1_s;
                    wv_r[3] <= wv_r[2];
                    wv_r[2] <= wv_r[1];
                    wv_r[1] <= wv_r[0];
                    wv_r[0] <= t1_s + t2_s;
                    // Wraps 63 -> 0, so w_ctr already reads 0 in FINAL and IDLE.
                    round_r <= round_r + 6'd1;
                    if (round_r == 6'd63) begin
                        state_r <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        hv_r[i] <= hv_r[i] + wv_r[i];
                    end
                    ready_r        <= 1'b1;
                    digest_valid_r <= 1'b1;
                    state_r        <= ST_IDLE;
                end
                default: begin
                    round_r <= 6'd0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_ctr        = round_r;
    assign ready        = ready_r;
    assign digest_valid = digest_valid_r;
    assign digest       = {hv_r[0], hv_r[1], hv_r[2], hv_r[3],
                           hv_r[4], hv_r[5], hv_r[6], hv_r[7]};

endmodule

// File: tb/tb_sha256_round_core.sv
// Self-checking bench for sha256_round_core: known vectors plus random blocks
// compared against an array-based SHA-256 compression model.
module tb_sha256_round_core;

    localparam logic [255:0] IV_REF = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk;
    logic         reset_n;
    logic         init;
    logic         next;
    logic [511:0] block;
    logic [5:0]   w_ctr;
    logic [31:0]  k_s;
    logic         ready;
    logic [255:0] digest;
    logic         digest_valid;

    int           checks;
    int           failures;
    logic [255:0] h_model;

    sha256_round_core dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .init         (init),
        .next         (next),
        .block        (block),
        .w_ctr        (w_ctr),
        .K            (k_s),
        .ready        (ready),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    // External K ROM, combinational on the round index.
    assign k_s = K_TAB[w_ctr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One SHA-256 compression: full 64-word schedule, then 64 rounds.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  hw [8];
        logic [31:0]  t1;
        logic [31:0]  t2;
        logic [255:0] res;
        for (int i = 0; i < 8; i++) begin
            hw[i] = hin[255 - 32*i -: 32];
            v[i]  = hw[i];
        end
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hw[i] + v[i];
        return res;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    // Runs one block from a negedge with the core idle. busy injects start
    // pulses while the core is busy; abort_at >= 0 drops reset at that round.
    task automatic run_block(input logic do_init, input logic do_next, input logic [511:0] blk,
                             input bit busy, input int abort_at);
        int   lat;
        logic seq_err;
        check_eq("ready_before_start", 256'(ready), 256'd1);
        init  = do_init;
        next  = do_next;
        block = blk;
        @(posedge clk);
        #1;
        init  = 1'b0;
        next  = 1'b0;
        block = rand_block();
        h_model = do_init ? ref_compress(IV_REF, blk) : ref_compress(h_model, blk);
        lat     = -1;
        seq_err = 1'b0;
        for (int i = 0; i <= 70 && lat < 0; i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                reset_n = 1'b0;
                #2;
                check_eq("abort_ready", 256'(ready), 256'd1);
                check_eq("abort_digest_valid", 256'(digest_valid), 256'd0);
                check_eq("abort_digest", digest, 256'd0);
                check_eq("abort_w_ctr", 256'(w_ctr), 256'd0);
                @(negedge clk);
                reset_n = 1'b1;
                h_model = 256'd0;
                return;
            end
            if (ready) begin
                lat = i;
            end else if (i < 64) begin
                if (int'(w_ctr) != i) seq_err = 1'b1;
            end else if (w_ctr != 6'd0) begin
                seq_err = 1'b1;
            end
            if (busy) begin
                init = (i == 10) || (i == 25);
                next = (i == 40) || (i == 25);
            end
        end
        init = 1'b0;
        next = 1'b0;
        check_eq("latency", 256'(lat), 256'd65);
        check_eq("w_ctr_sequence_err", 256'(seq_err), 256'd0);
        check_eq("w_ctr_idle", 256'(w_ctr), 256'd0);
        check_eq("digest_valid", 256'(digest_valid), 256'd1);
        check_eq("digest_model", digest, h_model);
    endtask

    initial begin
        logic [511:0] blk_abc;
        logic [511:0] blk_empty;
        logic [511:0] blk_two_a;
        logic [511:0] blk_two_b;
        int           mode;

        checks   = 0;
        failures = 0;
        h_model  = 256'd0;
        init     = 1'b0;
        next     = 1'b0;
        block    = 512'd0;
        reset_n  = 1'b0;

        blk_abc   = {32'h61626380, 448'd0, 32'h00000018};
        blk_empty = {32'h80000000, 480'd0};
        blk_two_a = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_two_b = {480'd0, 32'h000001c0};

        repeat (3) @(negedge clk);
        check_eq("reset_ready", 256'(ready), 256'd1);
        check_eq("reset_digest_valid", 256'(digest_valid), 256'd0);
        check_eq("reset_digest", digest, 256'd0);
        check_eq("reset_w_ctr", 256'(w_ctr), 256'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_block(1'b1, 1'b0, blk_abc, 1'b0, -1);
        check_eq("abc_digest", digest, DIG_ABC);

        run_block(1'b1, 1'b0, blk_empty, 1'b0, -1);
        check_eq("empty_digest", digest, DIG_EMPTY);

        run_block(1'b1, 1'b0, blk_two_a, 1'b0, -1);
        run_block(1'b0, 1'b1, blk_two_b, 1'b0, -1);
        check_eq("two_block_digest", digest, DIG_TWO);

        // Idle: digest holds while block wiggles and no start arrives.
        for (int i = 0; i < 5; i++) begin
            block = rand_block();
            @(negedge clk);
        end
        check_eq("idle_digest_hold", digest, DIG_TWO);
        check_eq("idle_valid_hold", 256'(digest_valid), 256'd1);

        run_block(1'b1, 1'b0, blk_abc, 1'b1, -1);
        check_eq("abc_busy_pulses", digest, DIG_ABC);

        run_block(1'b1, 1'b0, blk_two_a, 1'b0, -1);
        run_block(1'b1, 1'b1, blk_abc, 1'b0, -1);
        check_eq("init_next_together", digest, DIG_ABC);

        run_block(1'b1, 1'b0, blk_abc, 1'b0, 30);
        run_block(1'b1, 1'b0, blk_abc, 1'b0, -1);
        check_eq("abc_after_abort", digest, DIG_ABC);

        for (int n = 0; n < 6; n++) begin
            mode = $urandom_range(0, 2);
            run_block(mode != 1, mode != 0, rand_block(), 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
